// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared declarations for the multiport register file slice.
//   dump_state_e : states of the halt-triggered dump engine
//   DEF_DATA_W   : default register width
//   DEF_DEPTH    : default number of registers
//   field_lsb()  : bit offset of field idx inside a flattened port vector,
//                  used with +: to unpack/pack the per-port buses
// ---------------------------------------------------------------------------
package rf_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        DONE = 2'd2
    } dump_state_e;

    function automatic int field_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rf_dump_fsm.sv
// ---------------------------------------------------------------------------
// rf_dump_fsm
// Streams every register out over a valid/ready port once the processor
// halts. Storage is read through fetch_idx/fetch_data so this block owns no
// copy of the register contents.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   hlt          : processor halted, starts the dump from IDLE
//   dump_ready   : consumer accepts the current beat
//   fetch_idx    : register index to read from storage
//   fetch_data   : storage contents at fetch_idx
//   idle         : high while writes (and bypass) are allowed
//   dump_valid   : current beat valid
//   dump_idx     : register index of the current beat
//   dump_data    : register contents of the current beat
//   dump_done    : all registers transferred (sticky until rst)
// ---------------------------------------------------------------------------
module rf_dump_fsm
    import rf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hlt,
    input  logic              dump_ready,
    input  logic [DATA_W-1:0] fetch_data,
    output logic [ADDR_W-1:0] fetch_idx,
    output logic              idle,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done
);

    // One extra bit so the final increment past DEPTH-1 is unambiguous.
    localparam int               CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEPTH - 1);

    dump_state_e      state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            dump_valid <= 1'b0;
            dump_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hlt) begin
                        state      <= DUMP;
                        cnt        <= '0;
                        dump_valid <= 1'b1;
                    end
                end
                DUMP: begin
                    if (dump_valid && dump_ready) begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST) begin
                            state      <= DONE;
                            dump_valid <= 1'b0;
                            dump_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state      <= IDLE;
                    dump_valid <= 1'b0;
                    dump_done  <= 1'b0;
                end
            endcase
        end
    end

    // Storage is frozen outside IDLE, so passing fetch_data straight through
    // keeps dump_data stable under backpressure without a second register.
    assign dump_idx  = cnt[ADDR_W-1:0];
    assign fetch_idx = dump_idx;
    assign dump_data = dump_valid ? fetch_data : '0;
    assign idle      = (state == IDLE);

endmodule

// File: rtl/multiport_rf.sv
// ---------------------------------------------------------------------------
// multiport_rf
// Parametrised register file with NUM_RD read and NUM_WR write ports,
// same-cycle write-to-read bypass, optional hardwired-zero R0, selectable
// read latency (0 = combinational, 1 = registered) and a dump engine.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   rd_en/addr/data : packed read ports, port i at [i*W +: W]
//   wr_en/addr/data : packed write ports, higher index wins on conflict
//   hlt             : starts the register dump
//   dump_*          : valid/ready dump stream, dump_done when finished
// ---------------------------------------------------------------------------
module multiport_rf
    import rf_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int READ_LAT = 0,
    parameter int ZERO_R0  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     hlt,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [ADDR_W-1:0]        dump_idx,
    output logic [DATA_W-1:0]        dump_data,
    output logic                     dump_done
);

    logic [DATA_W-1:0]              regs [DEPTH];
    logic [NUM_WR-1:0][ADDR_W-1:0]  wr_addr_a;
    logic [NUM_WR-1:0][DATA_W-1:0]  wr_data_a;
    logic                           fsm_idle;
    logic [ADDR_W-1:0]              fetch_idx;
    logic [DATA_W-1:0]              fetch_data;

    for (genvar j = 0; j < NUM_WR; j++) begin : g_wr_unpack
        assign wr_addr_a[j] = wr_addr[field_lsb(j, ADDR_W) +: ADDR_W];
        assign wr_data_a[j] = wr_data[field_lsb(j, DATA_W) +: DATA_W];
    end

    // Ascending port order makes the highest-indexed write the last NBA,
    // so it wins on an address conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs[k] <= '0;
            end
        end else if (fsm_idle) begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && !(ZERO_R0 != 0 && wr_addr_a[j] == '0)) begin
                    regs[wr_addr_a[j]] <= wr_data_a[j];
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] eff;

        assign addr = rd_addr[field_lsb(i, ADDR_W) +: ADDR_W];

        // Bypass only while IDLE: outside IDLE the write never lands.
        always_comb begin
            eff = regs[addr];
            for (int j = 0; j < NUM_WR; j++) begin
                if (fsm_idle && wr_en[j] && wr_addr_a[j] == addr) begin
                    eff = wr_data_a[j];
                end
            end
            if (ZERO_R0 != 0 && addr == '0) begin
                eff = '0;
            end
        end

        if (READ_LAT == 0) begin : g_comb
            assign rd_data[field_lsb(i, DATA_W) +: DATA_W] = rd_en[i] ? eff : '0;
        end else begin : g_reg
            logic [DATA_W-1:0] q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    q <= '0;
                end else if (rd_en[i]) begin
                    q <= eff;
                end
            end

            assign rd_data[field_lsb(i, DATA_W) +: DATA_W] = q;
        end
    end

    assign fetch_data = (ZERO_R0 != 0 && fetch_idx == '0) ? '0 : regs[fetch_idx];

    rf_dump_fsm #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_dump_fsm (
        .clk        (clk),
        .rst        (rst),
        .hlt        (hlt),
        .dump_ready (dump_ready),
        .fetch_data (fetch_data),
        .fetch_idx  (fetch_idx),
        .idle       (fsm_idle),
        .dump_valid (dump_valid),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_done  (dump_done)
    );

endmodule

// File: tb/tb_multiport_rf.sv
// ---------------------------------------------------------------------------
// tb_multiport_rf
// Drives two register files (READ_LAT=0 and READ_LAT=1, both with two write
// ports) from the same inputs and compares them against a behavioural model.
// ---------------------------------------------------------------------------
module tb_multiport_rf;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int NR    = 2;
    localparam int NW    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [NR-1:0]    rd_en;
    logic [NR*AW-1:0] rd_addr;
    logic [NW-1:0]    wr_en;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*DW-1:0] wr_data;
    logic             hlt;
    logic             dump_ready;

    logic [NR*DW-1:0] rd_data_l0, rd_data_l1;
    logic             dump_valid_l0, dump_valid_l1;
    logic [AW-1:0]    dump_idx_l0, dump_idx_l1;
    logic [DW-1:0]    dump_data_l0, dump_data_l1;
    logic             dump_done_l0, dump_done_l1;

    multiport_rf #(
        .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
        .READ_LAT(0), .ZERO_R0(1)
    ) dut_l0 (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_l0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .hlt(hlt),
        .dump_valid(dump_valid_l0), .dump_ready(dump_ready), .dump_idx(dump_idx_l0),
        .dump_data(dump_data_l0), .dump_done(dump_done_l0)
    );

    multiport_rf #(
        .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
        .READ_LAT(1), .ZERO_R0(1)
    ) dut_l1 (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_l1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .hlt(hlt),
        .dump_valid(dump_valid_l1), .dump_ready(dump_ready), .dump_idx(dump_idx_l1),
        .dump_data(dump_data_l1), .dump_done(dump_done_l1)
    );

    // Reference model: architectural registers, latched read values and a
    // dump phase (0 idle, 1 dumping, 2 done) with the number of beats taken.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] lat1_q [NR];
    int            m_phase = 0;
    int            m_beat  = 0;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    bit chk_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Value a read port should see this cycle, straight from the rules.
    function automatic logic [DW-1:0] model_eff(input int p);
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        a = rd_addr[p*AW +: AW];
        v = mem[a];
        if (m_phase == 0) begin
            for (int j = 0; j < NW; j++) begin
                if (wr_en[j] && wr_addr[j*AW +: AW] == a) v = wr_data[j*DW +: DW];
            end
        end
        if (a == 0) v = '0;
        return v;
    endfunction

    task automatic model_commit();
        logic [DW-1:0] e [NR];
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) mem[k] = '0;
            for (int p = 0; p < NR; p++) lat1_q[p] = '0;
            m_phase = 0;
            m_beat  = 0;
        end else begin
            for (int p = 0; p < NR; p++) e[p] = model_eff(p);
            for (int p = 0; p < NR; p++) if (rd_en[p]) lat1_q[p] = e[p];
            if (m_phase == 0) begin
                for (int j = 0; j < NW; j++) begin
                    if (wr_en[j] && wr_addr[j*AW +: AW] != 0)
                        mem[wr_addr[j*AW +: AW]] = wr_data[j*DW +: DW];
                end
                if (hlt) begin
                    m_phase = 1;
                    m_beat  = 0;
                end
            end else if (m_phase == 1 && dump_ready) begin
                m_beat++;
                if (m_beat == DEPTH) m_phase = 2;
            end
        end
    endtask

    task automatic checkOutput();
        for (int p = 0; p < NR; p++) begin
            check($sformatf("rd_l0[%0d]", p), rd_data_l0[p*DW +: DW], rd_en[p] ? model_eff(p) : 16'h0);
            check($sformatf("rd_l1[%0d]", p), rd_data_l1[p*DW +: DW], lat1_q[p]);
        end
        check("dump_valid_l0", dump_valid_l0, m_phase == 1);
        check("dump_valid_l1", dump_valid_l1, m_phase == 1);
        check("dump_done_l0", dump_done_l0, m_phase == 2);
        check("dump_done_l1", dump_done_l1, m_phase == 2);
        if (m_phase == 1) begin
            check("dump_idx", dump_idx_l0, m_beat);
            check("dump_data", dump_data_l0, mem[m_beat]);
            check("dump_data_l1", dump_data_l1, mem[m_beat]);
        end else if (m_phase == 0) begin
            check("idle_dump_idx", dump_idx_l0, 0);
            check("idle_dump_data", dump_data_l0, 0);
        end
    endtask

    // Inputs are set during the low phase; outputs are checked 1 ns later,
    // then the cycle is committed at the rising edge.
    task automatic applyStimulus();
        #1;
        if (chk_en) checkOutput();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        hlt = 1'b0; dump_ready = 1'b0;
    endtask

    task automatic set_rd(input int p, input logic en, input logic [AW-1:0] a);
        rd_en[p] = en;
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic set_wr(input int p, input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en[p] = en;
        wr_addr[p*AW +: AW] = a;
        wr_data[p*DW +: DW] = d;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        applyStimulus();
        chk_en = 1'b1;

        // Reset state with reads enabled.
        set_rd(0, 1'b1, 4'd3); set_rd(1, 1'b1, 4'd7);
        applyStimulus();
        rst = 1'b0;
        #1;
        check("reset_rd0", rd_data_l0[0 +: DW], 16'h0);
        check("reset_rd1", rd_data_l0[DW +: DW], 16'h0);
        applyStimulus();

        // Write then read back.
        set_wr(0, 1'b1, 4'd5, 16'hBEEF);
        applyStimulus();
        set_wr(0, 1'b0, 4'd0, 16'h0); set_rd(0, 1'b1, 4'd5);
        #1;
        check("r5_readback", rd_data_l0[0 +: DW], 16'hBEEF);
        applyStimulus();

        // Same-cycle bypass.
        set_wr(0, 1'b1, 4'd4, 16'h1234); set_rd(0, 1'b1, 4'd4);
        #1;
        check("bypass_r4", rd_data_l0[0 +: DW], 16'h1234);
        applyStimulus();
        set_wr(0, 1'b0, 4'd0, 16'h0);
        #1;
        check("r4_after", rd_data_l0[0 +: DW], 16'h1234);
        check("r4_lat1_bypass", rd_data_l1[0 +: DW], 16'h1234);
        applyStimulus();

        // R0 hardwired zero.
        set_wr(0, 1'b1, 4'd0, 16'hFFFF); set_rd(0, 1'b1, 4'd0);
        #1;
        check("r0_bypass", rd_data_l0[0 +: DW], 16'h0);
        applyStimulus();
        set_wr(0, 1'b0, 4'd0, 16'h0);
        #1;
        check("r0_stored", rd_data_l0[0 +: DW], 16'h0);
        applyStimulus();

        // Write-port conflict: port 1 wins.
        set_wr(0, 1'b1, 4'd9, 16'h1111); set_wr(1, 1'b1, 4'd9, 16'h2222);
        set_rd(1, 1'b1, 4'd9);
        #1;
        check("conflict_bypass", rd_data_l0[DW +: DW], 16'h2222);
        applyStimulus();
        set_wr(0, 1'b0, 4'd0, 16'h0); set_wr(1, 1'b0, 4'd0, 16'h0);
        #1;
        check("conflict_stored", rd_data_l0[DW +: DW], 16'h2222);
        applyStimulus();

        // Registered read latency and hold.
        set_wr(0, 1'b1, 4'd2, 16'hA5A5);
        applyStimulus();
        set_wr(0, 1'b0, 4'd0, 16'h0); set_rd(0, 1'b1, 4'd2);
        applyStimulus();
        set_rd(0, 1'b0, 4'd2);
        #1;
        check("lat1_n1", rd_data_l1[0 +: DW], 16'hA5A5);
        applyStimulus();
        #1;
        check("lat1_hold", rd_data_l1[0 +: DW], 16'hA5A5);
        check("lat0_disabled", rd_data_l0[0 +: DW], 16'h0);
        applyStimulus();

        // Randomised traffic against the model.
        for (int c = 0; c < 150; c++) begin
            clear_inputs();
            rd_en   = NR'($urandom_range(0, 3));
            rd_addr = (NR*AW)'($urandom_range(0, 255));
            wr_en   = NW'($urandom_range(0, 3));
            wr_addr = (NW*AW)'($urandom_range(0, 255));
            wr_data = $urandom();
            applyStimulus();
        end

        // Preload R1..R15 and dump with backpressure.
        clear_inputs();
        for (int i = 1; i < DEPTH; i++) begin
            set_wr(0, 1'b1, AW'(i), 16'h0100 + 16'(i));
            applyStimulus();
        end
        clear_inputs();
        hlt = 1'b1;
        applyStimulus();
        hlt = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall_valid", dump_valid_l0, 1'b1);
            check("stall_idx", dump_idx_l0, 0);
            applyStimulus();
        end
        for (int k = 0; k < DEPTH; k++) begin
            dump_ready = 1'b1;
            set_wr(0, 1'b1, 4'd3, 16'hDEAD);
            #1;
            check("beat_idx", dump_idx_l0, k);
            check("beat_data", dump_data_l0, (k == 0) ? 32'h0 : 32'h0100 + k);
            applyStimulus();
        end
        clear_inputs();
        set_rd(0, 1'b1, 4'd3);
        hlt = 1'b1;
        #1;
        check("done_flag", dump_done_l0, 1'b1);
        check("done_valid", dump_valid_l0, 1'b0);
        check("r3_blocked", rd_data_l0[0 +: DW], 16'h0103);
        applyStimulus();
        applyStimulus();

        // Reset in the middle of a dump.
        clear_inputs();
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            set_wr(0, 1'b1, AW'(i), 16'h0200 + 16'(i));
            applyStimulus();
        end
        clear_inputs();
        hlt = 1'b1; dump_ready = 1'b1;
        applyStimulus();
        hlt = 1'b0;
        for (int k = 0; k < 6; k++) applyStimulus();
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        clear_inputs();
        set_rd(0, 1'b1, 4'd1); set_rd(1, 1'b1, 4'd5);
        #1;
        check("abort_valid", dump_valid_l0, 1'b0);
        check("abort_done", dump_done_l0, 1'b0);
        check("abort_r1", rd_data_l0[0 +: DW], 16'h0);
        check("abort_r5", rd_data_l0[DW +: DW], 16'h0);
        applyStimulus();
        hlt = 1'b1; dump_ready = 1'b1;
        applyStimulus();
        hlt = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            #1;
            check("restart_idx", dump_idx_l0, k);
            check("restart_data", dump_data_l0, 0);
            applyStimulus();
        end
        #1;
        check("restart_done", dump_done_l0, 1'b1);
        applyStimulus();

        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
